seq_divmod: RTL and testbench
=============================

SEQ_DIVMOD -- requirements
Module: seq_divmod

Interface
REQ-001 Parameter: DATAWIDTH, default 32, operand/result width in bits (>= 2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 a  input  DATAWIDTH  unsigned dividend; sampled with accepted start.
REQ-006 b  input  DATAWIDTH  unsigned divisor; sampled with accepted start.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; q, r, dbz valid.
REQ-009 q  output  DATAWIDTH  quotient, registered.
REQ-010 r  output  DATAWIDTH  remainder, registered.
REQ-011 dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE/DONE with start=1 at an edge SHALL latch a and b, clear the work remainder, and go to RUN (b!=0) or DONE (b=0).
REQ-014 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE after one cycle.
REQ-015 RUN SHALL perform one unsigned restoring step per cycle: shift {rem, dividend} left 1, subtract b if shifted rem >= b, set quotient LSB to 1 on subtract, else 0.
REQ-016 Comparison/subtraction SHALL use DATAWIDTH+1 bits so no overflow occurs for b > 2^(DATAWIDTH-1).
REQ-017 An iteration counter SHALL count exactly DATAWIDTH RUN cycles, then go to DONE.
REQ-018 Latency (b!=0): done=1 in the cycle after the DATAWIDTH-th edge following the accepting edge; start-to-done is DATAWIDTH+1 edges.
REQ-019 Latency (b=0): done=1 in the cycle after the accepting edge.
REQ-020 On entering DONE with b!=0: q=floor(a/b), r=a mod b, dbz=0.
REQ-021 On entering DONE with b=0: q=all ones, r=a, dbz=1.
REQ-022 q, r, dbz SHALL change only on entry to DONE and hold until the next completion or reset.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-024 start while busy=1 SHALL be ignored; a/b changes during RUN SHALL not affect the result.
REQ-025 start=1 in DONE SHALL be accepted at that edge (back-to-back, no idle cycle).
REQ-026 Edge cases: a=0 -> q=0, r=0; a<b -> q=0, r=a; b=1 -> q=a, r=0; a=b -> q=1, r=0.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, counter=0, busy=0, done=0, q=0, r=0, dbz=0, regardless of state.
REQ-028 rst SHALL take priority over start; an operation interrupted by rst SHALL be discarded with no done pulse.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification (DATAWIDTH=8)
REQ-030 a=100, b=7, start pulse -> busy for 8 cycles, then done=1 for one cycle with q=14, r=2, dbz=0.
REQ-031 a=5, b=0 -> done=1 in the next cycle, q=255, r=5, dbz=1, busy never high.
REQ-032 a=255/b=1 -> q=255, r=0; a=3/b=200 -> q=0, r=3; a=200/b=200 -> q=1, r=0.
REQ-033 Start held high continuously with a=50, b=6, and a/b changed mid-RUN -> first result q=8, r=2; the next operation starts in the DONE cycle, using the operands present at that edge.
REQ-034 rst asserted in the 4th RUN cycle -> busy=0, q=r=0 next cycle, no done pulse; subsequent 9/4 -> q=2, r=1.
REQ-035 Random unsigned a and b, including b=0 and b>=128, checked against a reference model -> zero mismatches over at least 10k operations.

Source files
------------

// File: rtl/seq_divmod.sv
// Sequential unsigned divider/modulo unit.
// Computes q = a / b and r = a % b with one restoring-division step per
// clock. A zero divisor completes immediately with q = all ones, r = a and
// dbz set.
module seq_divmod #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] q,
    output logic [DATAWIDTH-1:0] r,
    output logic                 dbz
);

    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATAWIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_count;
    logic [DATAWIDTH-1:0] r_divisor;
    logic [DATAWIDTH-1:0] r_dividend;
    logic [DATAWIDTH-1:0] r_rem;
    logic [DATAWIDTH-1:0] r_q;
    logic [DATAWIDTH-1:0] r_r;
    logic                 r_dbz;

    // One restoring step. The shifted remainder is one bit wider than the
    // operands so divisors above 2^(DATAWIDTH-1) cannot overflow. Because the
    // working remainder is always below the divisor, the difference lies in
    // [-divisor, divisor-1], so its top bit is a true sign/borrow bit.
    logic [DATAWIDTH:0]   w_shifted;
    logic [DATAWIDTH:0]   w_diff;
    logic                 w_ge;
    logic [DATAWIDTH-1:0] w_remNext;
    logic [DATAWIDTH-1:0] w_quoNext;

    assign w_shifted = {r_rem, r_dividend[DATAWIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_divisor};
    assign w_ge      = ~w_diff[DATAWIDTH];
    assign w_remNext = w_ge ? w_diff[DATAWIDTH-1:0] : w_shifted[DATAWIDTH-1:0];
    assign w_quoNext = {r_dividend[DATAWIDTH-2:0], w_ge};

    // Control FSM plus working registers: accept operands in IDLE/DONE,
    // iterate DATAWIDTH times in RUN, then pulse DONE for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dividend <= a;
                        r_divisor  <= b;
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_state    <= (b == '0) ? DONE : RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem      <= w_remNext;
                    r_dividend <= w_quoNext;
                    r_count    <= r_count + CW'(1);
                    if (r_count == LAST_COUNT) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result registers: these only change on the edge that enters DONE and
    // otherwise hold the last completed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else if ((r_state == IDLE || r_state == DONE) && start && (b == '0)) begin
            r_q   <= '1;
            r_r   <= a;
            r_dbz <= 1'b1;
        end else if (r_state == RUN && r_count == LAST_COUNT) begin
            r_q   <= w_quoNext;
            r_r   <= w_remNext;
            r_dbz <= 1'b0;
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign q    = r_q;
    assign r    = r_r;
    assign dbz  = r_dbz;

endmodule

// File: tb/tb_seq_divmod.sv
// Self-checking bench for seq_divmod at DATAWIDTH=8: directed corner cases,
// reset behaviour, back-to-back starts and a long randomized run against an
// arithmetic reference model.
module tb_seq_divmod;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;

    int compareCount  = 0;
    int mismatchCount = 0;

    seq_divmod #(.DATAWIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Launch one operation from a negedge where the DUT is in IDLE or DONE,
    // scramble the operands while it runs, and check latency and results
    // against plain integer arithmetic. Returns at the negedge where done is
    // seen, with start still high.
    task automatic applyStimulus(input logic [DW-1:0] ta, input logic [DW-1:0] tbv,
                                 input string tag);
        int            cycles;
        int            expLat;
        logic          expDbz;
        logic [DW-1:0] expQ;
        logic [DW-1:0] expR;
        expDbz = (tbv == 0);
        expQ   = expDbz ? {DW{1'b1}} : ta / tbv;
        expR   = expDbz ? ta : ta % tbv;
        expLat = expDbz ? 1 : DW + 1;
        a      = ta;
        b      = tbv;
        start  = 1'b1;
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        checkOutput({tag, " busy"}, {31'd0, busy}, {31'd0, ~expDbz});
        while (!done && cycles < 3 * DW) begin
            a = DW'($urandom);
            b = DW'($urandom);
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, " latency"}, cycles, expLat);
        checkOutput({tag, " q"}, {24'd0, q}, {24'd0, expQ});
        checkOutput({tag, " r"}, {24'd0, r}, {24'd0, expR});
        checkOutput({tag, " dbz"}, {31'd0, dbz}, {31'd0, expDbz});
    endtask

    logic [DW-1:0] edgeA [6] = '{8'd255, 8'd3,   8'd200, 8'd0, 8'd0, 8'd77};
    logic [DW-1:0] edgeB [6] = '{8'd1,   8'd200, 8'd200, 8'd9, 8'd0, 8'd255};

    initial begin
        int            sawDone;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 0);
        checkOutput("reset done", {31'd0, done}, 0);
        checkOutput("reset q", {24'd0, q}, 0);
        checkOutput("reset r", {24'd0, r}, 0);
        checkOutput("reset dbz", {31'd0, dbz}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic division, one-cycle done pulse and result hold.
        applyStimulus(8'd100, 8'd7, "100/7");
        start = 1'b0;
        @(negedge clk);
        checkOutput("100/7 done pulse", {31'd0, done}, 0);
        checkOutput("100/7 idle busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        checkOutput("100/7 hold q", {24'd0, q}, 14);
        checkOutput("100/7 hold r", {24'd0, r}, 2);

        // Divide by zero.
        applyStimulus(8'd5, 8'd0, "5/0");
        start = 1'b0;
        @(negedge clk);
        checkOutput("5/0 done pulse", {31'd0, done}, 0);

        // Corner operands.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(edgeA[i], edgeB[i], $sformatf("edge%0d", i));
            start = 1'b0;
            @(negedge clk);
        end

        // Start held high: second operation accepted in the DONE cycle.
        applyStimulus(8'd50, 8'd6, "held 50/6");
        applyStimulus(8'd17, 8'd3, "b2b 17/3");
        applyStimulus(8'd40, 8'd0, "b2b 40/0");
        applyStimulus(8'd9, 8'd2, "b2b 9/2");
        start = 1'b0;
        @(negedge clk);

        // Reset in the 4th RUN cycle discards the operation.
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("pre-rst busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst busy", {31'd0, busy}, 0);
        checkOutput("rst done", {31'd0, done}, 0);
        checkOutput("rst q", {24'd0, q}, 0);
        checkOutput("rst r", {24'd0, r}, 0);
        checkOutput("rst dbz", {31'd0, dbz}, 0);
        sawDone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) sawDone++;
        end
        checkOutput("no done after rst", sawDone, 0);
        applyStimulus(8'd9, 8'd4, "post-rst 9/4");
        start = 1'b0;
        @(negedge clk);

        // Randomized back-to-back operations, mixing zero and large divisors.
        for (int n = 0; n < 10000; n++) begin
            ra = DW'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = DW'($urandom_range(128, 255));
                default: rb = DW'($urandom_range(1, 255));
            endcase
            applyStimulus(ra, rb, $sformatf("rand%0d %0d/%0d", n, ra, rb));
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("final done pulse", {31'd0, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
